// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-port arbiter and its neighbours.
package cpu_pkg;

    localparam int unsigned MEM_SIZE = 65536;
    localparam int unsigned ADDR_W   = $clog2(MEM_SIZE);
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    // Command latched from the winning requester for the duration of an access
    typedef struct packed {
        arb_owner_t          owner;
        logic                we;
        logic [WORD_W-1:0]   wdata;
    } arb_cmd_t;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision between fetch and data requesters, with a saturating
// data-streak counter that forces a fetch grant after a run of data grants.
module mem_arb_select
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       halt_program,
    input  logic       if_req,
    input  logic       d_req,
    output logic       grant_c,
    output arb_owner_t owner_c
);

    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                fetch_forced;

    // Arbitration and streak bookkeeping; only meaningful while the FSM idles
    always_comb begin
        fetch_forced = if_req && (streak_q == STREAK_MAX);
        grant_c      = arb_en && !halt_program && (if_req || d_req);
        owner_c      = (d_req && !fetch_forced) ? OWN_D : OWN_IF;
        streak_d     = streak_q;

        if (arb_en) begin
            if (!if_req) begin
                streak_d = '0;
            end else if (grant_c) begin
                if (owner_c == OWN_IF) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide memory port between fetch and data requesters; each
// grant moves one little-endian 16-bit word as two byte cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_W          = cpu_pkg::ADDR_W,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_program,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [15:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    output logic [15:0]       d_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    import cpu_pkg::*;

    arb_state_t        state_q, state_d;
    arb_cmd_t          cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              grant_c;
    arb_owner_t        owner_c;

    mem_arb_select #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_select (
        .clk          (clk),
        .rst          (rst),
        .arb_en       (state_q == IDLE),
        .halt_program (halt_program),
        .if_req       (if_req),
        .d_req        (d_req),
        .grant_c      (grant_c),
        .owner_c      (owner_c)
    );

    // Next state plus the registered memory-port and ack values for that state
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        lo_d        = lo_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    cmd_d.owner = owner_c;
                    cmd_d.we    = (owner_c == OWN_D) && d_we;
                    cmd_d.wdata = d_wdata;
                    addr_d      = (owner_c == OWN_D) ? d_addr : if_addr;
                    mem_addr_d  = addr_d;
                    mem_we_d    = cmd_d.we;
                    mem_wdata_d = cmd_d.wdata[7:0];
                    state_d     = BYTE0;
                end
            end
            BYTE0: begin
                mem_addr_d  = addr_q + ADDR_W'(1);
                mem_we_d    = cmd_q.we;
                mem_wdata_d = cmd_q.wdata[15:8];
                state_d     = BYTE1;
            end
            BYTE1: begin
                lo_d     = mem_rdata;
                if_ack_d = (cmd_q.owner == OWN_IF);
                d_ack_d  = (cmd_q.owner == OWN_D);
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '{owner: OWN_IF, we: 1'b0, wdata: '0};
            addr_q      <= '0;
            lo_q        <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

    // The high byte leaves the memory's read register in the ack cycle itself,
    // so it is forwarded straight through; both words read zero outside ack.
    assign if_rdata = if_ack_q ? {mem_rdata, lo_q} : '0;
    assign d_rdata  = d_ack_q  ? {mem_rdata, lo_q} : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-level reference model predicts
// every grant, memory byte cycle and ack; a negedge monitor checks the DUT.
module tb_mem_arbiter;

    localparam int unsigned AW   = 16;
    localparam int          MAXS = 4;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          g;
    } exp_t;

    typedef struct {
        bit          is_d;
        int          cyc;
        logic [15:0] rdata;
    } log_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt_program = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [15:0]   if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [15:0]   d_wdata = '0;
    logic          d_ack;
    logic [15:0]   d_rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [7:0]    mem [0:65535];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   idle_at  = 0;
    int   streak   = 0;
    exp_t q[$];
    log_t ack_log[$];
    bit   rand_mode = 1'b0;
    int   if_cnt = 0;
    int   d_cnt  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W          (AW),
        .MAX_DATA_STREAK (MAXS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .halt_program (halt_program),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // 64 KiB byte memory with registered read
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: expected event did not occur", name, cyc);
    endtask

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    // Reference model: one word per 4-cycle slot, data first unless fetch has
    // waited through MAXS consecutive data grants.
    always @(posedge clk) begin
        bit          take_d;
        exp_t        e;
        logic [15:0] a;
        cyc++;
        if (rst) begin
            q.delete();
            streak  = 0;
            idle_at = cyc + 1;
        end else if (cyc >= idle_at) begin
            if (!halt_program && (if_req || d_req)) begin
                take_d = d_req && !(if_req && streak == MAXS);
                if (take_d && if_req) streak = (streak < MAXS) ? streak + 1 : MAXS;
                else streak = 0;
                a       = take_d ? d_addr : if_addr;
                e.is_d  = take_d;
                e.we    = take_d && d_we;
                e.addr  = a;
                e.wdata = d_wdata;
                e.rdata = {mem[16'(a + 16'd1)], mem[a]};
                e.g     = cyc;
                q.push_back(e);
                idle_at = cyc + 4;
            end else if (!if_req) begin
                streak = 0;
            end
        end
    end

    // Monitor: byte cycles in the two cycles after a grant, ack in the third
    always @(negedge clk) begin
        exp_t e;
        log_t l;
        int   d;
        if (!rst) begin
            if (q.size() > 0) begin
                e = q[0];
                d = cyc - e.g;
                if (d == 0) begin
                    chk("byte0_addr", 32'(mem_addr), 32'(e.addr));
                    chk("byte0_we", 32'(mem_we), 32'(e.we));
                    if (e.we) chk("byte0_wdata", 32'(mem_wdata), 32'(e.wdata[7:0]));
                end else if (d == 1) begin
                    chk("byte1_addr", 32'(mem_addr), 32'(16'(e.addr + 16'd1)));
                    chk("byte1_we", 32'(mem_we), 32'(e.we));
                    if (e.we) chk("byte1_wdata", 32'(mem_wdata), 32'(e.wdata[15:8]));
                end else if (d == 2) begin
                    chk("done_we", 32'(mem_we), 32'(0));
                end
                if (d >= 0 && d <= 2) chk("busy_active", 32'(busy), 32'(1));
            end
            if (if_ack || d_ack) begin
                l.is_d  = d_ack;
                l.cyc   = cyc;
                l.rdata = d_ack ? d_rdata : if_rdata;
                ack_log.push_back(l);
                if (q.size() == 0) begin
                    chk("spurious_ack", 32'({if_ack, d_ack}), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("ack_owner", 32'({if_ack, d_ack}), e.is_d ? 32'(2'b01) : 32'(2'b10));
                    chk("ack_cycle", 32'(cyc), 32'(e.g + 2));
                    if (!e.we) begin
                        chk(e.is_d ? "d_rdata" : "if_rdata", 32'(l.rdata), 32'(e.rdata));
                    end else begin
                        chk("store_lo", 32'(mem[e.addr]), 32'(e.wdata[7:0]));
                        chk("store_hi", 32'(mem[16'(e.addr + 16'd1)]), 32'(e.wdata[15:8]));
                    end
                end
            end else if (q.size() > 0 && cyc > q[0].g + 2) begin
                miss("ack_missing");
                void'(q.pop_front());
            end
        end
    end

    // Requester agents: hold request until acked, then drop or issue the next one
    initial begin : driver
        bit ia, da;
        forever begin
            @(negedge clk);
            ia = if_ack;
            da = d_ack;
            @(posedge clk);
            #1;
            if (ia && if_cnt > 0) begin
                if_cnt--;
                if (if_cnt == 0) if_req = 1'b0;
                else if (rand_mode) if_addr = rnd_addr();
            end
            if (da && d_cnt > 0) begin
                d_cnt--;
                if (d_cnt == 0) begin
                    d_req = 1'b0;
                    d_we  = 1'b0;
                end else if (rand_mode) begin
                    d_addr  = rnd_addr();
                    d_we    = 1'($urandom_range(0, 1));
                    d_wdata = 16'($urandom);
                end
            end
            if (rand_mode) begin
                if (if_cnt == 0 && $urandom_range(0, 3) == 0) begin
                    if_cnt  = $urandom_range(1, 3);
                    if_addr = rnd_addr();
                    if_req  = 1'b1;
                end
                if (d_cnt == 0 && $urandom_range(0, 2) == 0) begin
                    d_cnt   = $urandom_range(1, 6);
                    d_addr  = rnd_addr();
                    d_we    = 1'($urandom_range(0, 1));
                    d_wdata = 16'($urandom);
                    d_req   = 1'b1;
                end
                halt_program = ($urandom_range(0, 11) == 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (if_cnt == 0 && d_cnt == 0 && q.size() == 0 && !if_req && !d_req) begin
                tick();
                tick();
                return;
            end
            tick();
        end
        miss(name);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] saved;
        logic [6:0] seq;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0064] = 8'h34;
        mem[16'h0065] = 8'h12;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_if_ack", 32'(if_ack), 32'(0));
        chk("rst_d_ack", 32'(d_ack), 32'(0));
        chk("rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("rst_d_rdata", 32'(d_rdata), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        rst = 1'b0;
        repeat (2) tick();

        // Single fetch of 0x1234 from 0x0064
        ack_log.delete();
        if_addr = 16'h0064;
        if_cnt  = 1;
        if_req  = 1'b1;
        wait_idle("single_fetch_timeout");
        chk("single_fetch_acks", 32'(ack_log.size()), 32'(1));
        if (ack_log.size() > 0) begin
            chk("single_fetch_owner", 32'(ack_log[0].is_d), 32'(0));
            chk("single_fetch_rdata", 32'(ack_log[0].rdata), 32'(16'h1234));
        end

        // Simultaneous fetch and load: data first, fetch one slot later
        ack_log.delete();
        if_addr = 16'h0064;
        d_addr  = 16'h0200;
        d_we    = 1'b0;
        if_cnt  = 1;
        d_cnt   = 1;
        if_req  = 1'b1;
        d_req   = 1'b1;
        wait_idle("simul_timeout");
        chk("simul_acks", 32'(ack_log.size()), 32'(2));
        if (ack_log.size() == 2) begin
            chk("simul_order", 32'({ack_log[0].is_d, ack_log[1].is_d}), 32'(2'b10));
            chk("simul_spacing", 32'(ack_log[1].cyc - ack_log[0].cyc), 32'(4));
        end

        // Starvation guard: four data grants, then fetch, then data again
        ack_log.delete();
        if_addr = 16'h0080;
        d_addr  = 16'h0400;
        d_we    = 1'b0;
        if_cnt  = 1;
        d_cnt   = 6;
        if_req  = 1'b1;
        d_req   = 1'b1;
        wait_idle("starve_timeout");
        chk("starve_acks", 32'(ack_log.size()), 32'(7));
        if (ack_log.size() == 7) begin
            seq = '0;
            for (int i = 0; i < 7; i++) seq[6-i] = ack_log[i].is_d;
            chk("starve_order", 32'(seq), 32'(7'b1111011));
        end

        // Store wrapping from 0xFFFF to 0x0000
        ack_log.delete();
        d_addr  = 16'hFFFF;
        d_wdata = 16'hBEEF;
        d_we    = 1'b1;
        d_cnt   = 1;
        d_req   = 1'b1;
        wait_idle("wrap_timeout");
        chk("wrap_acks", 32'(ack_log.size()), 32'(1));
        chk("wrap_mem_ffff", 32'(mem[16'hFFFF]), 32'(8'hEF));
        chk("wrap_mem_0000", 32'(mem[16'h0000]), 32'(8'hBE));

        // Reset landing on the edge that would start the second byte of a store
        ack_log.delete();
        saved   = mem[16'h0301];
        d_addr  = 16'h0300;
        d_wdata = 16'hA55A;
        d_we    = 1'b1;
        d_cnt   = 1;
        d_req   = 1'b1;
        tick();
        rst   = 1'b1;
        d_req = 1'b0;
        d_we  = 1'b0;
        d_cnt = 0;
        tick();
        chk("midrst_mem_we", 32'(mem_we), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_mem_addr", 32'(mem_addr), 32'(0));
        chk("midrst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("midrst_d_ack", 32'(d_ack), 32'(0));
        rst = 1'b0;
        repeat (6) tick();
        chk("midrst_no_ack", 32'(ack_log.size()), 32'(0));
        chk("midrst_mem_0301", 32'(mem[16'h0301]), 32'(saved));

        // Halt with both requests pending, then release
        ack_log.delete();
        halt_program = 1'b1;
        if_addr = 16'h0100;
        d_addr  = 16'h0500;
        d_we    = 1'b0;
        if_cnt  = 1;
        d_cnt   = 1;
        if_req  = 1'b1;
        d_req   = 1'b1;
        repeat (4) begin
            tick();
            chk("halt_busy", 32'(busy), 32'(0));
        end
        chk("halt_no_ack", 32'(ack_log.size()), 32'(0));
        halt_program = 1'b0;
        tick();
        chk("resume_busy", 32'(busy), 32'(1));
        chk("resume_mem_addr", 32'(mem_addr), 32'(16'h0500));
        wait_idle("halt_timeout");
        chk("halt_acks", 32'(ack_log.size()), 32'(2));
        if (ack_log.size() == 2) begin
            chk("halt_order", 32'({ack_log[0].is_d, ack_log[1].is_d}), 32'(2'b10));
        end

        // Randomized traffic against the model
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode    = 1'b0;
        halt_program = 1'b0;
        wait_idle("drain_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
